// File: rtl/pipe_stage_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stage_ctrl
//   Control for a linear STAGES-deep instruction pipeline. Tracks which stages
//   hold live instructions. Generates per-stage enable/squash for the
//   pipeline registers. Handles stall back-propagation, per-stage kill and a
//   global flush. Keeps two performance counters.
//
// Ports
//   clk_i           clock, rising edge
//   reset_i         synchronous active-high reset
//   issue_valid_i   new instruction presented to stage 0
//   issue_ready_o   stage 0 accepts the presented instruction this cycle
//   stall_in_i      per-stage "needs another cycle" request
//   kill_in_i       per-stage discard of the resident instruction
//   flush_i         discard everything in flight plus the issuing instruction
//   out_stall_i     consumer of the last stage cannot accept
//   en_o            per-stage pipereg enable
//   squashn_o       per-stage pipereg squashn (0 = load a bubble)
//   valid_o         per-stage live flag (registered)
//   retire_o        last-stage instruction leaves this cycle
//   stall_cycles_o  saturating count of issue_valid & ~issue_ready cycles
//   retired_o       wrapping count of retire pulses
// -----------------------------------------------------------------------------
module pipe_stage_ctrl #(
   parameter int STAGES = 4,
   parameter int CNTW   = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              issue_valid_i,
   output logic              issue_ready_o,
   input  logic [STAGES-1:0] stall_in_i,
   input  logic [STAGES-1:0] kill_in_i,
   input  logic              flush_i,
   input  logic              out_stall_i,
   output logic [STAGES-1:0] en_o,
   output logic [STAGES-1:0] squashn_o,
   output logic [STAGES-1:0] valid_o,
   output logic              retire_o,
   output logic [CNTW-1:0]   stall_cycles_o,
   output logic [CNTW-1:0]   retired_o
);

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] live, stalled, vin;
   logic [CNTW-1:0]   stall_cycles_q, stall_cycles_d;
   logic [CNTW-1:0]   retired_q, retired_d;

   // Stall is resolved from the last stage back toward stage 0. A dead stage
   // (bubble, killed or flushed) breaks the chain, so the stage behind it may
   // still advance into the freed slot.
   always_comb begin
      live    = valid_q & ~kill_in_i & {STAGES{~flush_i}};
      stalled = '0;
      stalled[STAGES-1] = live[STAGES-1] & (stall_in_i[STAGES-1] | out_stall_i);
      for (int i = STAGES-2; i >= 0; i--) begin
         stalled[i] = live[i] & (stall_in_i[i] | stalled[i+1]);
      end
      vin    = '0;
      vin[0] = issue_valid_i & ~flush_i;
      for (int i = 1; i < STAGES; i++) begin
         vin[i] = live[i-1] & ~stalled[i-1];
      end
   end

   // A stalled stage is always live, so holding it equals keeping a 1.
   assign valid_d       = stalled | vin;
   assign en_o          = ~stalled;
   assign squashn_o     = stalled | vin;
   assign issue_ready_o = ~stalled[0] & ~flush_i;
   assign retire_o      = live[STAGES-1] & ~stalled[STAGES-1];
   assign valid_o       = valid_q;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (issue_valid_i && !issue_ready_o && (stall_cycles_q != {CNTW{1'b1}}))
         stall_cycles_d = stall_cycles_q + 1'b1;
      retired_d = retired_q + CNTW'(retire_o);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q        <= '0;
         stall_cycles_q <= '0;
         retired_q      <= '0;
      end else begin
         valid_q        <= valid_d;
         stall_cycles_q <= stall_cycles_d;
         retired_q      <= retired_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign retired_o      = retired_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_ctrl
//   Bench for pipe_stage_ctrl (STAGES=4). A 16-bit counter instance and an
//   8-bit counter instance share all inputs so counter saturation and wrap
//   can be reached in few cycles. The reference model tracks instruction
//   tags per slot and moves them according to the stall/kill/flush rules.
// -----------------------------------------------------------------------------
module tb_pipe_stage_ctrl;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         reset, issue_valid, flush, out_stall;
   logic [S-1:0] stall_in, kill_in;
   logic         issue_ready, retire, issue_ready8, retire8;
   logic [S-1:0] en, squashn, valid, en8, squashn8, valid8;
   logic [15:0]  stall_cycles, retired;
   logic [7:0]   stall_cycles8, retired8;

   always #5 clk = ~clk;

   pipe_stage_ctrl #(.STAGES(S), .CNTW(16)) dut (
      .clk_i(clk), .reset_i(reset), .issue_valid_i(issue_valid),
      .issue_ready_o(issue_ready), .stall_in_i(stall_in), .kill_in_i(kill_in),
      .flush_i(flush), .out_stall_i(out_stall), .en_o(en), .squashn_o(squashn),
      .valid_o(valid), .retire_o(retire), .stall_cycles_o(stall_cycles),
      .retired_o(retired));

   pipe_stage_ctrl #(.STAGES(S), .CNTW(8)) dut8 (
      .clk_i(clk), .reset_i(reset), .issue_valid_i(issue_valid),
      .issue_ready_o(issue_ready8), .stall_in_i(stall_in), .kill_in_i(kill_in),
      .flush_i(flush), .out_stall_i(out_stall), .en_o(en8), .squashn_o(squashn8),
      .valid_o(valid8), .retire_o(retire8), .stall_cycles_o(stall_cycles8),
      .retired_o(retired8));

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state: tag of the instruction in each slot, -1 = empty.
   int ids[S];
   int nid;
   int n_stall, n_ret;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < S; i++) ids[i] = -1;
      n_stall = 0;
      n_ret   = 0;
   endtask

   // One clock cycle: drive inputs, check every output against the model,
   // then advance the model across the rising edge.
   task automatic cyc(input bit rst, input bit iv, input bit [S-1:0] st,
                      input bit [S-1:0] kl, input bit fl, input bit os);
      bit [S-1:0] lv, stk, inc, e_en, e_sq, e_v;
      bit         e_rdy, e_ret;
      int         nxt[S];
      int         sc16, sc8;
      @(negedge clk);
      reset = rst; issue_valid = iv; stall_in = st; kill_in = kl;
      flush = fl; out_stall = os;
      for (int i = 0; i < S; i++) begin
         e_v[i] = (ids[i] >= 0);
         lv[i]  = (ids[i] >= 0) && !kl[i] && !fl;
      end
      // An instruction is stuck if, walking forward through an unbroken run
      // of live slots, some slot requests a stall (or the exit is blocked).
      for (int i = 0; i < S; i++) begin
         stk[i] = 1'b0;
         if (lv[i]) begin
            for (int j = i; j < S; j++) begin
               if (!lv[j]) break;
               if (st[j] || (j == S-1 && os)) begin
                  stk[i] = 1'b1;
                  break;
               end
            end
         end
      end
      inc[0] = iv && !fl;
      for (int i = 1; i < S; i++) inc[i] = lv[i-1] && !stk[i-1];
      e_en  = ~stk;
      e_sq  = stk | inc;
      e_rdy = !stk[0] && !fl;
      e_ret = lv[S-1] && !stk[S-1];
      sc16  = (n_stall > 65535) ? 65535 : n_stall;
      sc8   = (n_stall > 255) ? 255 : n_stall;
      #1;
      chk("valid",    valid,        e_v);
      chk("en",       en,           e_en);
      chk("squashn",  squashn,      e_sq);
      chk("ready",    issue_ready,  e_rdy);
      chk("retire",   retire,       e_ret);
      chk("stall_cyc", stall_cycles, sc16);
      chk("retired",  retired,      n_ret % 65536);
      chk("stall_cyc8", stall_cycles8, sc8);
      chk("retired8", retired8,     n_ret % 256);
      @(posedge clk);
      if (rst) mdl_clear();
      else begin
         for (int i = 0; i < S; i++) begin
            if (stk[i])       nxt[i] = ids[i];
            else if (!inc[i]) nxt[i] = -1;
            else if (i == 0) begin
               nxt[i] = nid;
               nid++;
            end else          nxt[i] = ids[i-1];
         end
         for (int i = 0; i < S; i++) ids[i] = nxt[i];
         if (iv && !e_rdy) n_stall++;
         if (e_ret)        n_ret++;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, '0, '0, 0, 0);
   endtask

   initial begin
      bit [S-1:0] rs, rk;
      nid = 0;
      reset = 1'b1; issue_valid = 1'b0; stall_in = '0; kill_in = '0;
      flush = 1'b0; out_stall = 1'b0;
      repeat (2) @(posedge clk);
      mdl_clear();

      // Reset cycle from cleared state: en all ones, no retire.
      cyc(1, 1, '0, '0, 0, 0);
      #1;
      chk("rst_valid", valid, 4'b0000);
      chk("rst_cnt",   stall_cycles, 16'h0000);

      // Free flow: a single issue reaches the last stage after 3 more cycles.
      cyc(0, 1, '0, '0, 0, 0);
      #1 chk("flow_t1", valid, 4'b0001);
      idle(3);
      #1 chk("flow_t4", valid, 4'b1000);
      chk("flow_ret", retire, 1'b1);
      idle(1);
      #1 chk("flow_cnt", retired, 16'h0001);

      // Stall absorbed by a bubble.
      cyc(0, 1, '0, '0, 0, 0);
      idle(1);
      cyc(0, 1, '0, '0, 0, 0);
      #1 chk("abs_pre", valid, 4'b0101);
      cyc(0, 0, 4'b0100, '0, 0, 0);
      #1 chk("abs_post", valid, 4'b0110);
      idle(4);

      // Back-pressure on a full pipe.
      repeat (4) cyc(0, 1, '0, '0, 0, 0);
      #1 chk("bp_full", valid, 4'b1111);
      repeat (3) cyc(0, 1, '0, '0, 0, 1);
      #1 chk("bp_hold", valid, 4'b1111);
      chk("bp_cnt", stall_cycles, 16'd3);

      // Kill on stage 2 breaks the stall chain from stage 3.
      cyc(0, 0, 4'b1000, 4'b0100, 0, 0);
      #1 chk("kill_v", valid, 4'b1110);

      // Flush overrides stalls.
      repeat (4) cyc(0, 1, '0, '0, 0, 0);
      cyc(0, 1, 4'b1111, '0, 1, 0);
      #1 chk("flush_v", valid, 4'b0000);

      // Sustained back-pressure saturates the narrow counter.
      repeat (4) cyc(0, 1, '0, '0, 0, 0);
      repeat (300) cyc(0, 1, '0, '0, 0, 1);
      #1 chk("sat8", stall_cycles8, 8'hFF);
      cyc(0, 1, '0, '0, 0, 1);
      #1 chk("sat8_hold", stall_cycles8, 8'hFF);

      // Reset clears saturated counter.
      cyc(1, 1, 4'b1111, '0, 1, 1);
      #1 chk("rst_sat", stall_cycles8, 8'h00);
      chk("rst_v", valid, 4'b0000);

      // Free flow long enough to wrap the narrow retire counter.
      repeat (300) cyc(0, 1, '0, '0, 0, 0);

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < S; i++) begin
            rs[i] = ($urandom_range(0, 99) < 15);
            rk[i] = ($urandom_range(0, 99) < 5);
         end
         cyc(($urandom_range(0, 999) < 3), ($urandom_range(0, 99) < 75), rs, rk,
             ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 30));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
